// File: rtl/serial_arith_unit_if.sv
// Bit-serial stream bundle for serial_arith_unit: word resync, input bit stream, mode select,
// and the registered result stream with its end-of-word markers.
interface serial_arith_unit_if;
    logic       clr;
    logic       in_valid;
    logic       in_bit;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    logic       out_flag;

    modport master (
        output clr, in_valid, in_bit, mode,
        input  out_valid, out_bit, out_last, out_flag
    );

    modport slave (
        input  clr, in_valid, in_bit, mode,
        output out_valid, out_bit, out_last, out_flag
    );
endinterface

// File: rtl/serial_arith_unit.sv
// Bit-serial increment / decrement / negate / pass unit on LSB-first words of WIDTH bits.
// All outputs are registered; one output bit per valid input bit.
//
// state | meaning
// PEND  | carry/borrow still pending (neg: no one seen yet)
// COPY  | remaining bits pass unchanged
// INV   | remaining bits inverted (neg after first one)
module serial_arith_unit #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_arith_unit_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] MODE_INC  = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_PEND = 2'b00,
        ST_COPY = 2'b01,
        ST_INV  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic             out_bit_q, out_bit_d;
    logic             out_last_q, out_last_d;
    logic             out_flag_q, out_flag_d;

    logic       first_bit;
    logic       last_bit;
    logic [1:0] mode_eff;
    state_t     state_eff;
    logic       b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PEND;
            idx_q       <= '0;
            mode_q      <= MODE_INC;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            out_flag_q  <= out_flag_d;
        end
    end

    // Bit 0 uses the live mode and a fresh start state, so the previous word's end state never leaks in.
    assign first_bit = (idx_q == '0);
    assign last_bit  = (idx_q == LAST_IDX);
    assign mode_eff  = first_bit ? bus.mode : mode_q;
    assign state_eff = first_bit ? ((bus.mode == MODE_PASS) ? ST_COPY : ST_PEND) : state_q;
    assign b         = bus.in_bit;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        out_valid_d = 1'b0;
        out_bit_d   = 1'b0;
        out_last_d  = 1'b0;
        out_flag_d  = 1'b0;

        if (bus.clr) begin
            idx_d   = '0;
            state_d = ST_PEND;
        end else if (bus.in_valid) begin
            mode_d      = mode_eff;
            idx_d       = last_bit ? '0 : idx_q + IDX_W'(1);
            out_valid_d = 1'b1;
            out_last_d  = last_bit;
            state_d     = state_eff;
            unique case (state_eff)
                ST_PEND: begin
                    unique case (mode_eff)
                        MODE_INC: begin
                            out_bit_d  = ~b;
                            state_d    = b ? ST_PEND : ST_COPY;
                            out_flag_d = last_bit & b;
                        end
                        MODE_DEC: begin
                            out_bit_d  = ~b;
                            state_d    = b ? ST_COPY : ST_PEND;
                            out_flag_d = last_bit & ~b;
                        end
                        MODE_NEG: begin
                            out_bit_d  = b;
                            state_d    = b ? ST_INV : ST_PEND;
                            out_flag_d = last_bit & b;
                        end
                        default: begin
                            out_bit_d = b;
                            state_d   = ST_COPY;
                        end
                    endcase
                end
                ST_COPY: out_bit_d = b;
                ST_INV:  out_bit_d = ~b;
                default: begin
                    out_bit_d = b;
                    state_d   = ST_PEND;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_flag  = out_flag_q;
endmodule

// File: tb/tb_serial_arith_unit.sv
// Directed bench for serial_arith_unit at WIDTH=4 and WIDTH=8; expected output records are
// queued from an arithmetic word model as stimulus is driven and popped one cycle later.
module tb_serial_arith_unit;
    localparam logic [1:0] INC  = 2'b00;
    localparam logic [1:0] DEC  = 2'b01;
    localparam logic [1:0] NEG  = 2'b10;
    localparam logic [1:0] PASS = 2'b11;

    typedef struct packed {
        logic v;
        logic b;
        logic l;
        logic f;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_arith_unit_if if4();
    serial_arith_unit_if if8();

    serial_arith_unit #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    serial_arith_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void model(input int w, input logic [31:0] v, input logic [1:0] m,
                                  output logic [31:0] r, output logic f);
        logic [31:0] mask;
        logic [31:0] vm;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        vm   = v & mask;
        case (m)
            INC:     begin r = (vm + 32'h1) & mask; f = (vm == mask);            end
            DEC:     begin r = (vm - 32'h1) & mask; f = (vm == 32'h0);           end
            NEG:     begin r = (~vm + 32'h1) & mask; f = (vm == (32'h1 << (w - 1))); end
            default: begin r = vm;                   f = 1'b0;                   end
        endcase
    endfunction

    function automatic exp_t observe(input int sel);
        if (sel == 8) return {if8.out_valid, if8.out_bit, if8.out_last, if8.out_flag};
        return {if4.out_valid, if4.out_bit, if4.out_last, if4.out_flag};
    endfunction

    task automatic check_front(input int sel, input string tag);
        exp_t got;
        exp_t want;
        want = exp_q.pop_front();
        got  = observe(sel);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed(v,b,l,f)=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic cyc(input int sel, input logic c, input logic v, input logic bi,
                       input logic [1:0] m, input exp_t e, input string tag);
        if (sel == 8) begin
            if8.clr = c; if8.in_valid = v; if8.in_bit = bi; if8.mode = m;
            if4.clr = 1'b0; if4.in_valid = 1'b0;
        end else begin
            if4.clr = c; if4.in_valid = v; if4.in_bit = bi; if4.mode = m;
            if8.clr = 1'b0; if8.in_valid = 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_front(sel, tag);
    endtask

    task automatic send_word(input int sel, input int w, input logic [31:0] value,
                             input logic [1:0] m, input logic gaps, input logic [1:0] alt_m,
                             input string tag);
        logic [31:0] res;
        logic        flg;
        logic        lst;
        model(w, value, m, res, flg);
        for (int i = 0; i < w; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2))
                    cyc(sel, 1'b0, 1'b0, 1'($urandom_range(0, 1)), alt_m, exp_t'(4'b0000),
                        {tag, "_gap"});
            end
            lst = (i == w - 1);
            cyc(sel, 1'b0, 1'b1, value[i], (i == 0) ? m : alt_m,
                {1'b1, res[i], lst, lst & flg}, tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        if4.clr = 1'b0; if4.in_valid = 1'b0; if4.in_bit = 1'b0; if4.mode = INC;
        if8.clr = 1'b0; if8.in_valid = 1'b0; if8.in_bit = 1'b0; if8.mode = INC;
        cyc(4, 1'b0, 1'b1, 1'b1, INC, exp_t'(4'b0000), "reset4");
        cyc(8, 1'b0, 1'b1, 1'b1, INC, exp_t'(4'b0000), "reset8");
        rst = 1'b0;
        cyc(4, 1'b0, 1'b0, 1'b0, INC, exp_t'(4'b0000), "idle");

        // Back-to-back words, no dead cycles between them.
        send_word(4, 4, 32'h7, INC, 1'b0, INC, "inc_0111");
        send_word(4, 4, 32'hF, INC, 1'b0, INC, "inc_1111");
        send_word(4, 4, 32'h0, DEC, 1'b0, DEC, "dec_0000");
        send_word(4, 4, 32'h4, DEC, 1'b0, DEC, "dec_0100");
        send_word(4, 4, 32'h6, NEG, 1'b0, NEG, "neg_0110");
        send_word(4, 4, 32'h8, NEG, 1'b0, NEG, "neg_1000");
        send_word(4, 4, 32'h0, NEG, 1'b0, NEG, "neg_0000");
        send_word(4, 4, 32'h9, PASS, 1'b0, PASS, "pass_1001");
        cyc(4, 1'b0, 1'b0, 1'b1, INC, exp_t'(4'b0000), "idle_after4");

        send_word(8, 8, 32'h3F, INC, 1'b1, DEC, "inc_3f_gaps");
        send_word(8, 8, 32'hA5, NEG, 1'b1, PASS, "neg_a5_gaps");
        cyc(8, 1'b0, 1'b0, 1'b0, INC, exp_t'(4'b0000), "idle_after8");

        // Two bits of an inc word on 11, then clr with a valid bit in the same cycle.
        cyc(4, 1'b0, 1'b1, 1'b1, INC, exp_t'(4'b1000), "pre_clr_b0");
        cyc(4, 1'b0, 1'b1, 1'b1, INC, exp_t'(4'b1000), "pre_clr_b1");
        cyc(4, 1'b1, 1'b1, 1'b1, DEC, exp_t'(4'b0000), "clr_with_valid");
        send_word(4, 4, 32'h5, INC, 1'b0, DEC, "inc_5_after_clr");

        // Inc word on x01: bits 1,0 give outputs 0,1; reset lands while bit 2 is presented.
        cyc(4, 1'b0, 1'b1, 1'b1, INC, exp_t'(4'b1000), "pre_rst_b0");
        cyc(4, 1'b0, 1'b1, 1'b0, INC, exp_t'(4'b1100), "pre_rst_b1");
        if4.in_valid = 1'b1; if4.in_bit = 1'b1;
        rst = 1'b1;
        exp_q.push_back(exp_t'(4'b0000));
        #1;
        check_front(4, "rst_async_clear");
        cyc(4, 1'b0, 1'b1, 1'b0, INC, exp_t'(4'b0000), "rst_held");
        rst = 1'b0;
        send_word(4, 4, 32'hA, PASS, 1'b0, INC, "pass_1010_after_rst");
        cyc(4, 1'b0, 1'b0, 1'b0, INC, exp_t'(4'b0000), "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
